// File: rtl/dff_input_conditioner.sv
// rtl/dff_input_conditioner.sv - synchronise, debounce and edge-detect a single-bit level
module dff_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             clr,
   output logic             q_clean,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] rise_cnt
);

   localparam int            CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   // Shift the raw level through the synchroniser chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
      end
   end

   // Debounce FSM; pulses, busy and q_clean are registered alongside state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= STABLE_LO;
         cnt     <= '0;
         q_clean <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (s) begin
                  state <= WAIT_HI;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  // Glitch: level fell back before it was qualified.
                  state <= STABLE_LO;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_HI;
                  q_clean <= 1'b1;
                  rise    <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!s) begin
                  state <= WAIT_LO;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state <= STABLE_HI;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= STABLE_LO;
                  q_clean <= 1'b0;
                  fall    <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE_LO;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Count rise pulses, saturating; clear wins over a coincident pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rise_cnt <= '0;
      end else if (clr) begin
         rise_cnt <= '0;
      end else if (rise && (rise_cnt != {CNT_W{1'b1}})) begin
         rise_cnt <= rise_cnt + 1'b1;
      end
   end

endmodule
